// File: rtl/axi_lite_cfg_poller_pkg.sv
// Shared parameters and types for the AXI-Lite configuration poller.
package axi_lite_cfg_poller_pkg;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    localparam int unsigned COMPUTE_TYPE_W = 4;

    // Compute-engine selector carried in config word 0 bits [5:2].
    typedef logic [COMPUTE_TYPE_W-1:0] compute_type_t;

    // Poller sequencing: idle gap, address phase, read-data phase.
    typedef enum logic [1:0] {
        ST_GAP = 2'd0,
        ST_AR  = 2'd1,
        ST_R   = 2'd2
    } poll_state_t;

endpackage

// File: rtl/axi_lite_cfg_poller.sv
// Round-robin AXI-Lite read master that mirrors N_REGS config words into shadow registers.
module axi_lite_cfg_poller
    import axi_lite_cfg_poller_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            N_REGS     = 4,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            POLL_GAP   = 16,
    parameter int unsigned            TIMEOUT    = 256,
    localparam int unsigned           IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [ADDR_WIDTH-1:0]        araddr,
    output logic [2:0]                   arprot,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic [1:0]                   rresp,
    output logic [N_REGS*DATA_WIDTH-1:0] cfg_regs,
    output logic                         upd_valid,
    output logic [IDX_W-1:0]             upd_idx,
    output logic                         start,
    output logic                         mixed,
    output compute_type_t                compute_type,
    output logic                         start_pulse,
    output logic [7:0]                   err_cnt,
    output logic                         timeout_flag
);

    localparam int unsigned      BYTES    = DATA_WIDTH / 8;
    localparam int unsigned      CNT_MAX  = (POLL_GAP > TIMEOUT) ? POLL_GAP : TIMEOUT;
    localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(POLL_GAP);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);

    poll_state_t           state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic                  arvalid_next, rready_next;
    logic [ADDR_WIDTH-1:0] araddr_next;
    logic                  upd_valid_next;
    logic [IDX_W-1:0]      upd_idx_next;
    logic [7:0]            err_cnt_next;
    logic                  timeout_next;
    logic                  start_pulse_next;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] shadow [N_REGS];

    // Next-state and next-output logic; the gap counter doubles as handshake wait timer.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        idx_next         = idx;
        arvalid_next     = 1'b0;
        rready_next      = 1'b0;
        araddr_next      = araddr;
        upd_valid_next   = 1'b0;
        upd_idx_next     = upd_idx;
        err_cnt_next     = err_cnt;
        timeout_next     = timeout_flag;
        start_pulse_next = 1'b0;
        wr_en            = 1'b0;
        unique case (state)
            ST_GAP: begin
                if (cnt < GAP_LIM) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if ((cnt >= GAP_LIM) && enable) begin
                    state_next   = ST_AR;
                    cnt_next     = '0;
                    arvalid_next = 1'b1;
                    araddr_next  = BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES);
                end
            end
            ST_AR: begin
                arvalid_next = 1'b1;
                if (arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = ST_R;
                    cnt_next     = '0;
                end else begin
                    if (cnt < TO_LIM) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                    if (cnt_next >= TO_LIM) begin
                        timeout_next = 1'b1;
                    end
                end
            end
            ST_R: begin
                rready_next = 1'b1;
                if (rvalid) begin
                    rready_next = 1'b0;
                    state_next  = ST_GAP;
                    cnt_next    = '0;
                    idx_next    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    if (rresp == AXI_RESP_OKAY) begin
                        wr_en            = 1'b1;
                        upd_valid_next   = 1'b1;
                        upd_idx_next     = idx;
                        start_pulse_next = (idx == '0) && rdata[0] && !shadow[0][0];
                    end else if (err_cnt != 8'hFF) begin
                        err_cnt_next = err_cnt + 8'd1;
                    end
                end else begin
                    if (cnt < TO_LIM) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                    if (cnt_next >= TO_LIM) begin
                        timeout_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_GAP;
                cnt_next   = '0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_GAP;
            cnt          <= '0;
            idx          <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            araddr       <= BASE_ADDR;
            upd_valid    <= 1'b0;
            upd_idx      <= '0;
            err_cnt      <= '0;
            timeout_flag <= 1'b0;
            start_pulse  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            arvalid      <= arvalid_next;
            rready       <= rready_next;
            araddr       <= araddr_next;
            upd_valid    <= upd_valid_next;
            upd_idx      <= upd_idx_next;
            err_cnt      <= err_cnt_next;
            timeout_flag <= timeout_next;
            start_pulse  <= start_pulse_next;
        end
    end

    // Shadow copies of the polled words, written only on OKAY responses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[idx] <= rdata;
        end
    end

    // Flatten shadow words onto the cfg_regs bus.
    for (genvar g = 0; g < int'(N_REGS); g++) begin : g_pack
        assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = shadow[g];
    end

    assign arprot       = AXI_PROT_DEFAULT;
    assign start        = shadow[0][0];
    assign mixed        = shadow[0][1];
    assign compute_type = compute_type_t'(shadow[0][5:2]);

endmodule

// File: tb/tb_axi_lite_cfg_poller.sv
// Scoreboard bench: stimulus queues expected AR addresses and shadow updates, monitor checks them.
`timescale 1ns/1ps
module tb_axi_lite_cfg_poller;
    import axi_lite_cfg_poller_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } upd_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              enable = 1'b0;
    logic              arvalid, arready, rvalid, rready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic [NR*DW-1:0]  cfg_regs;
    logic              upd_valid, start, mixed, start_pulse, timeout_flag;
    logic [1:0]        upd_idx;
    compute_type_t     compute_type;
    logic [7:0]        err_cnt;

    axi_lite_cfg_poller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REGS(NR),
        .BASE_ADDR('0), .POLL_GAP(0), .TIMEOUT(256)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .cfg_regs(cfg_regs), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .start(start), .mixed(mixed), .compute_type(compute_type),
        .start_pulse(start_pulse), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
    );

    always #5 aclk = ~aclk;

    // Slave model: memory table plus response table, single outstanding read.
    logic          ar_allow = 1'b1;
    logic          r_allow = 1'b1;
    logic          r_pend;
    logic [AW-1:0] r_addr;
    logic [31:0]   mem [NR];
    logic [1:0]    resp_mem [NR];

    assign arready = ar_allow;
    assign rvalid  = r_pend & r_allow;
    assign rdata   = mem[r_addr[3:2]];
    assign rresp   = resp_mem[r_addr[3:2]];

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pend <= 1'b0;
            r_addr <= '0;
        end else if (arvalid && arready) begin
            r_pend <= 1'b1;
            r_addr <= araddr;
        end else if (rvalid && rready) begin
            r_pend <= 1'b0;
        end
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   ar_cnt = 0;
    int   pulse_cycles = 0;
    int   arvalid_cycles = 0;
    int   cyc = 0;
    int   ar_t_prev = 0;
    int   ar_t_last = 0;
    int   m_idx = 0;
    logic [AW-1:0] exp_ar_q [$];
    upd_t          exp_upd_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an AR handshake or an update.
    always @(negedge aclk) begin
        upd_t u;
        cyc++;
        if (aresetn) begin
            if (arvalid) arvalid_cycles++;
            if (start_pulse) pulse_cycles++;
            if (arvalid && arready) begin
                ar_cnt++;
                ar_t_prev = ar_t_last;
                ar_t_last = cyc;
                check("arprot", 64'(arprot), 64'(AXI_PROT_DEFAULT));
                if (exp_ar_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ar_unexpected: got araddr 0x%0h expected no request", araddr);
                end else begin
                    check("araddr", 64'(araddr), 64'(exp_ar_q.pop_front()));
                end
            end
            if (upd_valid) begin
                if (exp_upd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL upd_unexpected: got upd_idx %0d expected no update", upd_idx);
                end else begin
                    u = exp_upd_q.pop_front();
                    check("upd_idx", 64'(upd_idx), 64'(u.idx));
                    check("upd_word", 64'(cfg_regs[int'(u.idx)*32 +: 32]), 64'(u.data));
                end
            end
        end
    end

    // Queue the expected AR address and, for OKAY slots, the expected shadow update.
    task automatic expect_next();
        upd_t u;
        exp_ar_q.push_back(AW'(m_idx) * 32'd4);
        if (resp_mem[m_idx] == 2'b00) begin
            u.idx  = 2'(m_idx);
            u.data = mem[m_idx];
            exp_upd_q.push_back(u);
        end
        m_idx = (m_idx + 1) % NR;
    endtask

    // Let exactly n address handshakes happen, then drop enable while the last one is in R.
    task automatic do_reads_raw(input int n);
        int target;
        int c;
        target = ar_cnt + n;
        c = 0;
        enable = 1'b1;
        while (ar_cnt < target && c < n * 10 + 50) begin
            @(posedge aclk);
            c++;
        end
        #1 enable = 1'b0;
        if (ar_cnt < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_budget: got %0d handshakes expected %0d", ar_cnt, target);
        end
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) expect_next();
        do_reads_raw(n);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge aclk);
        while ((arvalid || rready || exp_upd_q.size() != 0) && c < 100) begin
            @(negedge aclk);
            c++;
        end
        if (c >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", c);
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   stable_bad;
        int   c;
        int   av;
        logic [AW-1:0] hold_addr;

        mem[0] = 32'h0000_0010; mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222; mem[3] = 32'h3333_3333;
        for (int i = 0; i < int'(NR); i++) resp_mem[i] = 2'b00;

        // Reset values.
        repeat (3) @(posedge aclk);
        #1;
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_start_pulse", 64'(start_pulse), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_timeout", 64'(timeout_flag), 64'd0);
        for (int i = 0; i < int'(NR); i++) check("rst_cfg_word", 64'(cfg_regs[i*32 +: 32]), 64'd0);
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("idle_no_enable", 64'(arvalid_cycles), 64'd0);

        // Back-to-back polling: addresses 0,4,8,C,0 and three cycles per transaction.
        do_reads(5);
        wait_idle();
        check("loop_period", 64'(ar_t_last - ar_t_prev), 64'd3);
        check("decode_start_0x10", 64'(start), 64'd0);
        check("decode_type_0x10", 64'(compute_type), 64'h4);

        // Word 0 becomes 0x1D: decode and single start pulse.
        mem[0] = 32'h0000_001D;
        do_reads(4);
        wait_idle();
        check("start", 64'(start), 64'd1);
        check("mixed", 64'(mixed), 64'd0);
        check("compute_type", 64'(compute_type), 64'h7);
        check("pulse_once", 64'(pulse_cycles), 64'd1);
        do_reads(4);
        wait_idle();
        check("no_repulse", 64'(pulse_cycles), 64'd1);

        // SLVERR on idx 2 keeps the shadow and counts an error; then saturation.
        resp_mem[2] = 2'b10;
        mem[2] = 32'hBAD0_BAD0;
        do_reads(4);
        wait_idle();
        check("err_shadow_kept", 64'(cfg_regs[2*32 +: 32]), 64'h2222_2222);
        check("err_cnt_one", 64'(err_cnt), 64'd1);
        for (int i = 0; i < int'(NR); i++) resp_mem[i] = 2'b10;
        do_reads(300);
        wait_idle();
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        for (int i = 0; i < int'(NR); i++) resp_mem[i] = 2'b00;

        // arready stuck low: stable request, timeout at 256, no abort even with enable dropped.
        ar_allow = 1'b0;
        expect_next();
        enable = 1'b1;
        c = 0;
        while (!arvalid && c < 20) begin
            @(posedge aclk);
            #1;
            c++;
        end
        check("ar_seen", 64'(arvalid), 64'd1);
        hold_addr = araddr;
        check("ar_hold_addr", 64'(hold_addr), 64'h4);
        stable_bad = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge aclk);
            #1;
            if (!arvalid || araddr !== hold_addr) stable_bad++;
            if (i == 100) enable = 1'b0;
            if (i == 255) check("timeout_pre", 64'(timeout_flag), 64'd0);
            if (i == 256) check("timeout_set", 64'(timeout_flag), 64'd1);
        end
        check("ar_stable", 64'(stable_bad), 64'd0);
        ar_allow = 1'b1;
        wait_idle();
        check("timeout_sticky", 64'(timeout_flag), 64'd1);

        // enable dropped during R: transaction finishes, then the poller parks.
        r_allow = 1'b0;
        do_reads(1);
        repeat (5) @(posedge aclk);
        #1;
        check("r_held", 64'(rready), 64'd1);
        av = arvalid_cycles;
        r_allow = 1'b1;
        repeat (20) @(posedge aclk);
        #1;
        check("parked", 64'(arvalid_cycles - av), 64'd0);
        wait_idle();

        // Reset while in R: rready drops at once, restart from BASE_ADDR.
        r_allow = 1'b0;
        exp_ar_q.push_back(AW'(m_idx) * 32'd4);
        do_reads_raw(1);
        repeat (3) @(posedge aclk);
        #2;
        check("pre_rst_rready", 64'(rready), 64'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_rready", 64'(rready), 64'd0);
        check("mid_rst_arvalid", 64'(arvalid), 64'd0);
        check("mid_rst_err", 64'(err_cnt), 64'd0);
        check("mid_rst_timeout", 64'(timeout_flag), 64'd0);
        check("mid_rst_word0", 64'(cfg_regs[31:0]), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        r_allow = 1'b1;
        m_idx = 0;
        do_reads(1);
        wait_idle();
        check("post_rst_start", 64'(start), 64'd1);
        check("post_rst_pulse", 64'(pulse_cycles), 64'd2);

        check("ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
        check("upd_q_drained", 64'(exp_upd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
